// File: rtl/iir_coef_sequencer.sv
// iir_coef_sequencer: shadow/active coefficient banks for one biquad IIR,
// with a glitch-free commit sequence (bypass, clear, swap, settle, re-enable).
// Optional build macro: IIR_STABILITY_CHECK_EN rejects commits whose shadow
// d1/d2 pair would give an unstable biquad.
//
// state   | meaning
// --------+---------------------------------------------------------------
// INIT    | post-reset filter clear, CLEAR_CYC cycles
// RUN     | normal operation, filt_enable follows en_req, commits accepted
// BYPASS  | filter bypassed ahead of the clear, BYPASS_CYC cycles
// CLEAR   | filt_reset asserted, CLEAR_CYC cycles
// SWAP    | one cycle, active bank copies the whole shadow bank
// SETTLE  | bypass held after the swap, SETTLE_CYC cycles
module iir_coef_sequencer #(
    parameter logic [17:0] N1_INIT    = 18'h078B4,
    parameter logic [17:0] N2_INIT    = 18'h3169E,
    parameter logic [17:0] N3_INIT    = 18'h070AC,
    parameter logic [17:0] D1_INIT    = 18'h0F04C,
    parameter logic [17:0] D2_INIT    = 18'h38F30,
    parameter int unsigned BYPASS_CYC = 4,
    parameter int unsigned CLEAR_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [17:0] wr_data,
    input  logic        commit,
    input  logic        en_req,
    output logic [17:0] coef_n1,
    output logic [17:0] coef_n2,
    output logic [17:0] coef_n3,
    output logic [17:0] coef_d1,
    output logic [17:0] coef_d2,
    output logic        filt_reset,
    output logic        filt_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_INIT, S_RUN, S_BYPASS, S_CLEAR, S_SWAP, S_SETTLE
    } state_t;

    localparam logic [7:0] BYP = 8'(BYPASS_CYC);
    localparam logic [7:0] CLR = 8'(CLEAR_CYC);
    localparam logic [7:0] SET = 8'(SETTLE_CYC);
    localparam logic [17:0] INIT_VAL [5] = '{N1_INIT, N2_INIT, N3_INIT, D1_INIT, D2_INIT};

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [17:0] shadow [5];
    logic [17:0] active [5];
    logic        stable;
    logic        commit_ok;
    logic        err_set;
    logic        filt_reset_nxt, filt_enable_nxt, busy_nxt;

`ifdef IIR_STABILITY_CHECK_EN
    logic signed [19:0] d1_s, d2_s, d1_abs, d2_abs, d1_lim;

    // Biquad stability triangle on the shadow d1/d2, evaluated in the commit cycle
    always_comb begin
        d1_s   = {{2{shadow[3][17]}}, shadow[3]};
        d2_s   = {{2{shadow[4][17]}}, shadow[4]};
        d1_abs = d1_s[19] ? -d1_s : d1_s;
        d2_abs = d2_s[19] ? -d2_s : d2_s;
        d1_lim = 20'sd32768 - d2_s;
        stable = (d2_abs < 20'sd32768) && (d1_abs < d1_lim);
    end
`else
    assign stable = 1'b1;
`endif

    assign commit_ok = commit && (state == S_RUN) && stable;
    assign err_set   = (wr_en && (wr_addr > 3'd4))
                     || (commit && (state != S_RUN))
                     || (commit && (state == S_RUN) && !stable);

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            cnt         <= 8'd0;
            filt_reset  <= 1'b1;
            filt_enable <= 1'b0;
            busy        <= 1'b1;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            filt_reset  <= filt_reset_nxt;
            filt_enable <= filt_enable_nxt;
            busy        <= busy_nxt;
            err         <= err | err_set;
        end
    end

    // Next state; the counter is loaded on entry and a timed state exits at 1.
    // INIT starts from a zero counter, so its first cycle loads CLEAR_CYC-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT: begin
                if (cnt == 8'd1 || (cnt == 8'd0 && CLR == 8'd1)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'd0) begin
                    cnt_nxt = CLR - 8'd1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_RUN: begin
                if (commit_ok) begin
                    state_nxt = S_BYPASS;
                    cnt_nxt   = BYP;
                end
            end
            S_BYPASS: begin
                if (cnt == 8'd1) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = CLR;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_CLEAR: begin
                if (cnt == 8'd1) begin
                    state_nxt = S_SWAP;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_SWAP: begin
                state_nxt = S_SETTLE;
                cnt_nxt   = SET;
            end
            S_SETTLE: begin
                if (cnt == 8'd1) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        filt_reset_nxt  = (state_nxt == S_INIT) || (state_nxt == S_CLEAR);
        filt_enable_nxt = (state_nxt == S_RUN) && en_req;
        busy_nxt        = (state_nxt != S_RUN);
    end

    // Coefficient banks; the swap copies the shadow before any same-cycle write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++) begin
                shadow[i] <= INIT_VAL[i];
                active[i] <= INIT_VAL[i];
            end
        end else begin
            if (state == S_SWAP) begin
                for (int i = 0; i < 5; i++) active[i] <= shadow[i];
            end
            for (int i = 0; i < 5; i++) begin
                if (wr_en && (wr_addr == 3'(i))) shadow[i] <= wr_data;
            end
        end
    end

    assign coef_n1 = active[0];
    assign coef_n2 = active[1];
    assign coef_n3 = active[2];
    assign coef_d1 = active[3];
    assign coef_d2 = active[4];

endmodule

// File: tb/tb_iir_coef_sequencer.sv
// Self-checking bench for iir_coef_sequencer: directed steps followed by a
// randomized phase, checked against a bank/timing model kept in the bench.
module tb_iir_coef_sequencer;

    localparam int B     = 4;
    localparam int C     = 2;
    localparam int S     = 8;
    localparam int LAST  = B + C + S + 2;
    localparam int SWAPN = B + C + 2;
    localparam logic [17:0] INIT_V [5] = '{18'h078B4, 18'h3169E, 18'h070AC, 18'h0F04C, 18'h38F30};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [17:0] wr_data = 18'd0;
    logic        commit = 1'b0;
    logic        en_req = 1'b1;
    logic [17:0] coef_n1, coef_n2, coef_n3, coef_d1, coef_d2;
    logic        filt_reset, filt_enable, busy, err;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] shadow_m [5];
    logic [17:0] active_m [5];
    logic        err_m;

    iir_coef_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .en_req      (en_req),
        .coef_n1     (coef_n1),
        .coef_n2     (coef_n2),
        .coef_n3     (coef_n3),
        .coef_d1     (coef_d1),
        .coef_d2     (coef_d2),
        .filt_reset  (filt_reset),
        .filt_enable (filt_enable),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic busy_e, input logic fe_e, input logic fr_e);
        check({tag, ".busy"}, 32'(busy), 32'(busy_e));
        check({tag, ".fen"},  32'(filt_enable), 32'(fe_e));
        check({tag, ".frst"}, 32'(filt_reset), 32'(fr_e));
        check({tag, ".err"},  32'(err), 32'(err_m));
        check({tag, ".n1"},   32'(coef_n1), 32'(active_m[0]));
        check({tag, ".n2"},   32'(coef_n2), 32'(active_m[1]));
        check({tag, ".n3"},   32'(coef_n3), 32'(active_m[2]));
        check({tag, ".d1"},   32'(coef_d1), 32'(active_m[3]));
        check({tag, ".d2"},   32'(coef_d2), 32'(active_m[4]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            shadow_m[i] = INIT_V[i];
            active_m[i] = INIT_V[i];
        end
        err_m = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [17:0] d);
        if (a < 3'd5) shadow_m[a] = d;
        else          err_m = 1'b1;
    endtask

    function automatic bit stable_m();
`ifdef IIR_STABILITY_CHECK_EN
        int d1, d2, a1, a2;
        d1 = int'($signed(shadow_m[3]));
        d2 = int'($signed(shadow_m[4]));
        a1 = (d1 < 0) ? -d1 : d1;
        a2 = (d2 < 0) ? -d2 : d2;
        return (a2 < 32768) && (a1 < 32768 - d2);
`else
        return 1'b1;
`endif
    endfunction

    // Single write issued while in RUN, then RUN outputs checked
    task automatic do_write(input string tag, input logic [2:0] a, input logic [17:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        model_write(a, d);
        check_state(tag, 1'b0, en_req, 1'b0);
    endtask

    // Commit from RUN and follow the whole sequence cycle by cycle.
    // wr_at / cm_at: cycle index at which an extra write / commit is driven
    // (0 = together with the commit, -1 = none).
    task automatic run_commit(input string tag, input int wr_at, input logic [2:0] wa,
                              input logic [17:0] wd, input int cm_at);
        bit acc;
        acc = stable_m();
        commit = 1'b1;
        if (wr_at == 0) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        step();
        commit = 1'b0; wr_en = 1'b0;
        if (wr_at == 0) model_write(wa, wd);
        if (!acc) begin
            err_m = 1'b1;
            check_state({tag, ".rej"}, 1'b0, en_req, 1'b0);
            return;
        end
        for (int n = 1; n <= LAST; n++) begin
            check_state($sformatf("%s@%0d", tag, n), n < LAST,
                        (n >= LAST) ? en_req : 1'b0, (n > B) && (n <= B + C));
            if (n == LAST) break;
            if (wr_at == n) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
            if (cm_at == n) commit = 1'b1;
            step();
            commit = 1'b0; wr_en = 1'b0;
            if (n + 1 == SWAPN) active_m = shadow_m;
            if (wr_at == n) model_write(wa, wd);
            if (cm_at == n) err_m = 1'b1;
        end
    endtask

    initial begin
        // Reset state and post-reset INIT clear
        model_reset();
        reset = 1'b0; en_req = 1'b1;
        step(); step();
        check_state("rst", 1'b1, 1'b0, 1'b1);
        #2 reset = 1'b1;
        step();
        check_state("init1", 1'b1, 1'b0, 1'b1);
        step();
        check_state("run0", 1'b0, 1'b1, 1'b0);
        check("init_n1", 32'(coef_n1), 32'h078B4);

        // Basic commit of a new n1
        do_write("wr_n1", 3'd0, 18'h10000);
        run_commit("seq_n1", -1, 3'd0, 18'd0, -1);
        check("seq_n1.val", 32'(coef_n1), 32'h10000);

        // Invalid address: dropped, err set
        do_write("wr_bad", 3'd6, 18'h3FFFF);

        // Reset falling during CLEAR
        commit = 1'b1; step(); commit = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid.frst", 32'(filt_reset), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check_state("mid_rst", 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        check_state("mid_init", 1'b1, 1'b0, 1'b1);
        step();
        check_state("mid_run", 1'b0, en_req, 1'b0);

        // Commit with same-cycle write, a second commit mid-sequence, then back-to-back
        en_req = 1'b0;
        run_commit("cw", 0, 3'd1, 18'h01234, 4);
        run_commit("settle_wr", 10, 3'd1, 18'h2AAAA, -1);
        run_commit("swap_wr", B + C + 1, 3'd0, 18'h15555, -1);
        en_req = 1'b1;
        run_commit("apply", -1, 3'd0, 18'd0, -1);

`ifdef IIR_STABILITY_CHECK_EN
        // Stability check: unstable d2 rejected without latency
        reset = 1'b0; #1; model_reset(); reset = 1'b1;
        step(); step();
        check_state("stab_run", 1'b0, en_req, 1'b0);
        do_write("stab_wr", 3'd4, 18'h08000);
        run_commit("stab", -1, 3'd0, 18'd0, -1);
        check("stab.d2", 32'(coef_d2), 32'h38F30);
        do_write("stab_wr2", 3'd4, 18'h3C000);
        do_write("stab_wr3", 3'd3, 18'h08000);
        run_commit("stab_ok", -1, 3'd0, 18'd0, -1);
`endif

        // Randomized phase
        for (int it = 0; it < 10; it++) begin
            int nw, wa_i, cm_i;
            en_req = 1'($urandom_range(0, 1));
            step();
            check_state($sformatf("rnd%0d.idle", it), 1'b0, en_req, 1'b0);
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                logic [2:0] a;
                a = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
                do_write($sformatf("rnd%0d.wr", it), a, 18'($urandom));
            end
            wa_i = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, LAST - 1);
            cm_i = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LAST - 1) : -1;
            run_commit($sformatf("rnd%0d", it), wa_i, 3'($urandom_range(0, 4)),
                       18'($urandom), cm_i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iir_coef_sequencer.md
# iir_coef_sequencer

Configuration controller for the self-trigger biquad IIR filter. It holds a shadow bank and an active bank of five Q2.15 coefficients. On a commit request it runs the filter through a glitch-free swap: bypass, clear the filter state, swap the coefficients, let the filter settle, then re-enable it. It sits between the slow-control register interface and one filter instance and drives that instance's coefficient, reset and enable inputs.

## Interface
Parameters:
- `N1_INIT`, 18'h078B4: active/shadow reset value for n1.
- `N2_INIT`, 18'h3169E: reset value for n2.
- `N3_INIT`, 18'h070AC: reset value for n3.
- `D1_INIT`, 18'h0F04C: reset value for d1.
- `D2_INIT`, 18'h38F30: reset value for d2.
- `BYPASS_CYC`, 4: cycles the filter is held bypassed before clear (1..255).
- `CLEAR_CYC`, 2: cycles `filt_reset` is asserted (1..255).
- `SETTLE_CYC`, 8: cycles bypass is held after the swap (1..255).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: shadow write strobe.
- `wr_addr` in 3: 0=n1, 1=n2, 2=n3, 3=d1, 4=d2; 5..7 are invalid.
- `wr_data` in 18: signed Q2.15 coefficient.
- `commit` in 1: single-cycle request to apply the shadow bank.
- `en_req` in 1: user request to filter (0 = pass raw samples).
- `coef_n1`, `coef_n2`, `coef_n3`, `coef_d1`, `coef_d2` out 18 each: active bank.
- `filt_reset` out 1: active-high reset to the filter.
- `filt_enable` out 1: filter enable (0 = bypass).
- `busy` out 1: a sequence is in progress.
- `err` out 1: sticky error flag; cleared only by `reset`.

## Operation
States: INIT, RUN, BYPASS, CLEAR, SWAP, SETTLE.

While `reset` is low:
- Active bank = shadow bank = `*_INIT`.
- `filt_reset`=1, `filt_enable`=0, `busy`=1, `err`=0.
- State = INIT, cycle counter = 0.

State behaviour:
- INIT: holds `filt_reset`=1 for `CLEAR_CYC` cycles after reset release, then goes to RUN.
- RUN: `busy`=0 and `filt_enable` = `en_req`. A `commit` goes to BYPASS.
- BYPASS: `filt_enable`=0 for `BYPASS_CYC` cycles, then goes to CLEAR.
- CLEAR: `filt_reset`=1 and `filt_enable`=0 for `CLEAR_CYC` cycles, then goes to SWAP.
- SWAP: one cycle. The active bank takes the whole shadow bank atomically. `filt_enable`=0. Goes to SETTLE.
- SETTLE: `filt_enable`=0 for `SETTLE_CYC` cycles, then goes to RUN.

Counter: one 8-bit down-counter, loaded on entry to each timed state; the state exits when the counter reads 1.

Writes and commits:
- A `wr_en` in any state updates the shadow entry at `wr_addr`.
- A write with `wr_addr`>4 is dropped and sets `err`.
- A write issued in the SWAP cycle lands in the shadow bank after the copy, so it is not applied by this sequence.
- A `commit` while `busy`=1 is ignored and sets `err`; the sequence in progress is unaffected.
- A `commit` and `wr_en` in the same RUN cycle: the write is captured, and the swap applies it.
- If `reset` falls mid-sequence, the block returns immediately to INIT with `*_INIT` coefficients; the shadow bank is also reinitialised.
- The active bank changes only in SWAP or under reset, never while `filt_enable`=1.
- `en_req` is sampled only in RUN. In every other state `filt_enable` is forced to 0.

## Timing
- All outputs are registered.
- `commit` sampled high at edge k:
  - `busy`=1 and `filt_enable`=0 from edge k+1.
  - `filt_reset` is high for edges k+1+BYPASS_CYC .. k+BYPASS_CYC+CLEAR_CYC.
  - The new coefficients are visible from edge k+BYPASS_CYC+CLEAR_CYC+2.
  - `busy`=0 and `filt_enable`=`en_req` from edge k+BYPASS_CYC+CLEAR_CYC+SETTLE_CYC+2.
  - Total with defaults: 16 cycles.
- After reset release: RUN is reached CLEAR_CYC cycles later.
- The earliest accepted back-to-back commit is the first cycle with `busy`=0.
- `err` rises one cycle after the offending input.

## Configuration
- `IIR_STABILITY_CHECK_EN` defined: in RUN, a `commit` first checks the shadow bank for biquad stability, with d2 and d1 as signed Q2.15:
  - Pass condition: |d2| < 32768 and |d1| < 32768 − d2, evaluated in 20-bit signed arithmetic.
  - On failure the commit is rejected, `err` is set, the state stays RUN and the active bank is unchanged.
  - The check adds no latency: it is combinational on the shadow registers, evaluated in the commit cycle.
- Not defined: every commit is accepted with no check.

## Test plan
- Reset release with `en_req`=1 → `filt_reset`=1 for 2 cycles, then `filt_enable`=1, `busy`=0, coefficients = INIT values (n1=0x078B4).
- Write n1=0x10000, then commit in RUN → `filt_enable` drops next cycle; `filt_reset` high on cycles 5–6; `coef_n1`=0x10000 at cycle 8; `busy`=0 at cycle 16.
- Second commit at cycle 5 of an active sequence → `err`=1; the sequence timing is unchanged.
- Write to `wr_addr`=6 → `err`=1 and no coefficient changes. Write n2 during SETTLE → the shadow bank updates, and the active bank is unchanged until the next commit.
- `reset` low in the CLEAR state → all coefficients return to INIT, and the INIT sequence repeats.
- With `IIR_STABILITY_CHECK_EN`: write d2=0x08000 (+1.0), then commit → rejected, `err`=1, `busy` stays 0, `coef_d2`=0x38F30.
